// File: rtl/video_cfg_scheduler.sv
// Frame-synchronous configuration scheduler: stages key-control settings,
// waits for them to settle, commits on vsync and supervises the ack.
module video_cfg_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned ACK_TIMEOUT   = 4096,
    parameter int unsigned THR_MAX       = 255,
    parameter logic [12:0] DEF_CHANGE_EN = 13'h0040
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  working_mode_i,
    input  logic [12:0] change_en_i,
    input  logic [2:0]  rgb_ctrl_i,
    input  logic [2:0]  r_ctrl_i,
    input  logic [2:0]  g_ctrl_i,
    input  logic [2:0]  b_ctrl_i,
    input  logic [20:0] threshold_i,
    input  logic [2:0]  change_choose_i,
    input  logic        change_yuv_i,
    input  logic        change_sobel_i,
    input  logic        vs_in,
    input  logic        cfg_ack,
    input  logic        err_clr,
    output logic [1:0]  working_mode_o,
    output logic [12:0] change_en_o,
    output logic [2:0]  rgb_ctrl_o,
    output logic [2:0]  r_ctrl_o,
    output logic [2:0]  g_ctrl_o,
    output logic [2:0]  b_ctrl_o,
    output logic [2:0]  change_choose_o,
    output logic        change_yuv_o,
    output logic        change_sobel_o,
    output logic [7:0]  threshold_o,
    output logic        scale_state_o,
    output logic        cfg_update,
    output logic        cfg_pending,
    output logic        ack_err,
    output logic [7:0]  frame_cnt
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [AW-1:0] ACK_LAST    = AW'(ACK_TIMEOUT - 1);
    localparam logic [20:0]   THR_LIM     = 21'(THR_MAX);
    localparam logic [7:0]    THR_CLAMP   = 8'(THR_MAX);

    typedef enum logic [2:0] {
        IDLE, SETTLE, WAIT_VS, COMMIT, WAIT_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [52:0]   stage_q, stage_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [AW-1:0] ack_q, ack_d;
    logic          pend_q, pend_d;
    logic          upd_q, upd_d;
    logic          err_q, err_d;
    logic          vs_q;
    logic [7:0]    fcnt_q;
    logic          load;
    logic          err_set;

    logic [52:0]   cfg_in;
    logic          diff;
    logic          vs_rise;
    logic [12:0]   st_ce;
    logic [20:0]   st_thr;
    logic [2:0]    st_ch;
    logic [12:0]   ce_c;
    logic [7:0]    thr_c;
    logic [2:0]    ch_c;

    assign cfg_in = {working_mode_i, change_en_i, rgb_ctrl_i, r_ctrl_i,
                     g_ctrl_i, b_ctrl_i, threshold_i, change_choose_i,
                     change_yuv_i, change_sobel_i};
    assign diff    = (cfg_in != stage_q);
    assign vs_rise = vs_in & ~vs_q;

    assign st_ce  = stage_q[50:38];
    assign st_thr = stage_q[25:5];
    assign st_ch  = stage_q[4:2];

    assign ce_c  = $onehot(st_ce) ? st_ce : DEF_CHANGE_EN;
    assign ch_c  = (st_ch <= 3'd5) ? st_ch : 3'd0;
    assign thr_c = st_thr[20]          ? 8'd0 :
                   (st_thr > THR_LIM)  ? THR_CLAMP :
                                         st_thr[7:0];

    // Next-state and handshake decisions of the commit sequencer.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        settle_d = settle_q;
        ack_d    = ack_q;
        pend_d   = pend_q;
        upd_d    = 1'b0;
        load     = 1'b0;
        err_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (diff) begin
                    stage_d  = cfg_in;
                    settle_d = '0;
                    pend_d   = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (diff) begin
                    stage_d  = cfg_in;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = WAIT_VS;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            WAIT_VS: begin
                if (diff) begin
                    stage_d  = cfg_in;
                    settle_d = '0;
                    state_d  = SETTLE;
                end else if (vs_rise) begin
                    load    = 1'b1;
                    upd_d   = 1'b1;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                ack_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (cfg_ack) begin
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else if (ack_q == ACK_LAST) begin
                    err_set = 1'b1;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_set | (err_q & ~err_clr);
    end

    // Sequencer state, staging and handshake flags.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            settle_q <= '0;
            ack_q    <= '0;
            pend_q   <= 1'b0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            settle_q <= settle_d;
            ack_q    <= ack_d;
            pend_q   <= pend_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    // Vsync edge tracking and frame counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_q   <= 1'b0;
            fcnt_q <= '0;
        end else begin
            vs_q <= vs_in;
            if (vs_rise) fcnt_q <= fcnt_q + 8'd1;
        end
    end

    // Committed configuration, loaded only on the vsync commit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            working_mode_o  <= '0;
            change_en_o     <= DEF_CHANGE_EN;
            rgb_ctrl_o      <= '0;
            r_ctrl_o        <= '0;
            g_ctrl_o        <= '0;
            b_ctrl_o        <= '0;
            threshold_o     <= '0;
            change_choose_o <= '0;
            change_yuv_o    <= 1'b0;
            change_sobel_o  <= 1'b0;
            scale_state_o   <= (DEF_CHANGE_EN >= 13'h0080);
        end else if (load) begin
            working_mode_o  <= stage_q[52:51];
            change_en_o     <= ce_c;
            rgb_ctrl_o      <= stage_q[37:35];
            r_ctrl_o        <= stage_q[34:32];
            g_ctrl_o        <= stage_q[31:29];
            b_ctrl_o        <= stage_q[28:26];
            threshold_o     <= thr_c;
            change_choose_o <= ch_c;
            change_yuv_o    <= stage_q[1];
            change_sobel_o  <= stage_q[0];
            scale_state_o   <= (ce_c >= 13'h0080);
        end
    end

    assign cfg_update  = upd_q;
    assign cfg_pending = pend_q;
    assign ack_err     = err_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: doc/video_cfg_scheduler.md
Name: video_cfg_scheduler

Overview:
Frame-synchronous configuration scheduler between the push-button control block and the HDMI video-processing pipeline. It captures the button-driven settings (mode, scale select, colour offsets, Sobel threshold, effect select) and waits for them to stay stable for a settle window. It then commits them to the pipeline only on a vsync rising edge, so no frame is processed with a mixed configuration. Downstream confirms each commit with a cfg_ack handshake, which is timeout-supervised.

Parameters:
SETTLE_CYCLES, 1000, cycles the inputs must stay unchanged before a commit is armed (>=2)
ACK_TIMEOUT, 4096, max cycles to wait for cfg_ack after cfg_update
THR_MAX, 255, upper clamp for threshold_o (<=255)
DEF_CHANGE_EN, 13'h0040, reset and fallback scale select (one-hot)

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
working_mode_i  in  2  processing mode from key control
change_en_i  in  13  one-hot scale select
rgb_ctrl_i, r_ctrl_i, g_ctrl_i, b_ctrl_i  in  3 each  colour offset steps
threshold_i  in  21  Sobel threshold (may have wrapped below zero)
change_choose_i  in  3  effect select 0..5
change_yuv_i, change_sobel_i  in  1 each  effect enables
vs_in  in  1  frame vsync, active-high, sys_clk-synchronous
cfg_ack  in  1  downstream accepted the committed config
err_clr  in  1  clears ack_err
working_mode_o, change_en_o, rgb/r/g/b_ctrl_o, change_choose_o, change_yuv_o, change_sobel_o  out  same widths as inputs  committed config
threshold_o  out  8  clamped committed threshold
scale_state_o  out  1  1 when change_en_o >= 13'h0080
cfg_update  out  1  one-cycle pulse: new config is valid on the outputs
cfg_pending  out  1  a change is staged but not yet acknowledged
ack_err  out  1  sticky flag: ack timeout occurred
frame_cnt  out  8  vsync rising-edge counter

Behaviour:
- Reset values: change_en_o = DEF_CHANGE_EN. All other outputs, staging registers and counters are 0. State = IDLE. vs_d = 0.
- Vsync edge: vs_rise = vs_in & ~vs_d, where vs_d is a registered copy of vs_in. frame_cnt increments on every vs_rise in any state and wraps 255 -> 0.
- Change detection: "diff" means the concatenated inputs differ from the staging register.
- IDLE: on diff, load staging, clear settle_cnt, set cfg_pending = 1, go to SETTLE.
- SETTLE: on diff, reload staging and clear settle_cnt. Otherwise increment settle_cnt. When settle_cnt == SETTLE_CYCLES-1, go to WAIT_VS.
- WAIT_VS: diff takes priority over vs_rise in the same cycle; on diff, reload staging, clear settle_cnt, go to SETTLE. Otherwise, on vs_rise, go to COMMIT.
- COMMIT (1 cycle):
  - Outputs are loaded from staging. cfg_update = 1 in the cycle the new outputs first appear.
  - Then go to WAIT_ACK and clear ack_cnt.
- Commit rules:
  - threshold_o = 0 if staging threshold[20] = 1 (underflow). Else THR_MAX if the value > THR_MAX. Else the value[7:0].
  - change_en_o = staging value if it is exactly one-hot, else DEF_CHANGE_EN.
  - change_choose_o = staging value if <= 5, else 0.
  - scale_state_o is updated in the same cycle from the committed change_en_o.
- WAIT_ACK:
  - cfg_ack is sampled only in this state; an ack coincident with the cfg_update cycle is ignored.
  - On cfg_ack, clear cfg_pending and go to IDLE.
  - Otherwise ack_cnt increments. When ack_cnt == ACK_TIMEOUT-1, set ack_err, clear cfg_pending, go to IDLE.
  - Input changes are not staged here. IDLE detects them next cycle against the committed staging.
- ack_err clear: cleared by err_clr. If set and clear occur in the same cycle, set wins.
- Outputs other than cfg_update change only in COMMIT.
- Asynchronous reset mid-operation returns everything to the reset values. No commit is issued.
- Latency: last input change -> cfg_update is >= SETTLE_CYCLES + 2 cycles, and ends at the first vs_rise after the settle window + 1 cycle.

Test Plan:
- Reset, no input activity, 3 vsync pulses -> change_en_o = 13'h0040, cfg_update never asserted, frame_cnt = 3.
- Set r_ctrl_i = 3 and hold; vsync pulses at 500 and 1500 cycles (SETTLE_CYCLES = 1000) -> no commit at the 500-cycle vsync; cfg_update exactly 1 cycle after the 1500-cycle vs_rise; r_ctrl_o = 3; cfg_ack 2 cycles later -> cfg_pending = 0.
- threshold_i = 21'h1FFFFB (wrapped -5) -> threshold_o = 0. threshold_i = 300 -> threshold_o = 255. threshold_i = 40 -> threshold_o = 40.
- change_en_i = 13'h0041 (not one-hot) -> change_en_o = 13'h0040. change_en_i = 13'h0100 -> scale_state_o = 1.
- Change the input in the same cycle as vs_rise while in WAIT_VS -> no commit; settle window restarts; commit on a later vsync carries the new value.
- Withhold cfg_ack for ACK_TIMEOUT = 16 cycles -> ack_err = 1, FSM returns to IDLE. Assert err_clr together with a new timeout event -> ack_err stays 1. err_clr alone -> ack_err = 0.
